// File: rtl/mero_alu_pkg.sv
// Shared ALU control codes, mul/div function encodings and sequencer state type.
// MULDIV_DIV_EN enables DIVU/REMU; without it only MUL is accepted.
package mero_alu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0011;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10,
    MD_RSVD = 2'b11
  } md_funct_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } md_state_e;

  // Operations this build can execute; anything else takes the reject path.
  function automatic logic md_supported(input logic [1:0] f);
`ifdef MULDIV_DIV_EN
    return f != MD_RSVD;
`else
    return f == MD_MUL;
`endif
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response and shared-ALU borrowing signals of the mul/div sequencer.
interface muldiv_seq_if;
  import mero_alu_pkg::*;

  logic                  start_i;
  logic [1:0]            funct_i;
  logic [DATA_W-1:0]     op1_i;
  logic [DATA_W-1:0]     op2_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [DATA_W-1:0]     result_o;
  logic                  alu_req_o;
  logic [ALU_CTRL_W-1:0] alu_ctrl_o;
  logic [DATA_W-1:0]     alu_op1_o;
  logic [DATA_W-1:0]     alu_op2_o;
  logic [DATA_W-1:0]     alu_data_i;

  modport master (
    output start_i, funct_i, op1_i, op2_i, alu_data_i,
    input  busy_o, done_o, err_o, result_o, alu_req_o, alu_ctrl_o, alu_op1_o, alu_op2_o
  );

  modport slave (
    input  start_i, funct_i, op1_i, op2_i, alu_data_i,
    output busy_o, done_o, err_o, result_o, alu_req_o, alu_ctrl_o, alu_op1_o, alu_op2_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One shift-add (MUL) or restoring-divide iteration: ALU operands and next register values.
// hi = acc/rem, lo = mc/quo, arg = mp/divisor. Divide path exists only with MULDIV_DIV_EN.
module muldiv_step
  import mero_alu_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  md_funct_e             funct,
`endif
  input  logic [DATA_W-1:0]     hi,
  input  logic [DATA_W-1:0]     lo,
  input  logic [DATA_W-1:0]     arg,
  input  logic [DATA_W-1:0]     alu_data,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0]     hi_nxt,
  output logic [DATA_W-1:0]     lo_nxt,
  output logic [DATA_W-1:0]     arg_nxt
);

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0] sh;
  logic            take;
`endif

  always_comb begin
    alu_op1  = hi;
    alu_op2  = lo;
    alu_ctrl = ALU_ADD;
    hi_nxt   = arg[0] ? alu_data : hi;
    lo_nxt   = lo << 1;
    arg_nxt  = arg >> 1;
`ifdef MULDIV_DIV_EN
    sh   = {hi, lo[DATA_W-1]};
    take = sh[DATA_W] | (sh[DATA_W-1:0] >= arg);
    if (funct != MD_MUL) begin
      alu_op1  = sh[DATA_W-1:0];
      alu_op2  = arg;
      alu_ctrl = ALU_SUB;
      hi_nxt   = take ? alu_data : sh[DATA_W-1:0];
      lo_nxt   = {lo[DATA_W-2:0], take};
      arg_nxt  = arg;
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the shared ALU for 32 cycles.
// MULDIV_DIV_EN enables the divide path; otherwise DIVU/REMU are rejected like funct 11.
module muldiv_seq
  import mero_alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  muldiv_seq_if.slave bus
);

  md_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     hi_q, lo_q, arg_q;
  logic                  busy_q, done_q, err_q, alu_req_q;
  logic [DATA_W-1:0]     result_q;
`ifdef MULDIV_DIV_EN
  md_funct_e             funct_q;
`endif

  logic [DATA_W-1:0]     step_op1, step_op2, hi_nxt, lo_nxt, arg_nxt, res_nxt;
  logic [ALU_CTRL_W-1:0] step_ctrl;

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .funct    (funct_q),
`endif
    .hi       (hi_q),
    .lo       (lo_q),
    .arg      (arg_q),
    .alu_data (bus.alu_data_i),
    .alu_op1  (step_op1),
    .alu_op2  (step_op2),
    .alu_ctrl (step_ctrl),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt),
    .arg_nxt  (arg_nxt)
  );

`ifdef MULDIV_DIV_EN
  assign res_nxt = (funct_q == MD_DIVU) ? lo_nxt : hi_nxt;
`else
  assign res_nxt = hi_nxt;
`endif

  // Sequencer FSM; the final iteration's next value is captured straight into result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      arg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      alu_req_q <= 1'b0;
      result_q  <= '0;
`ifdef MULDIV_DIV_EN
      funct_q   <= MD_MUL;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            busy_q <= 1'b1;
            if (md_supported(bus.funct_i)) begin
              state_q   <= ST_CALC;
              alu_req_q <= 1'b1;
              cnt_q     <= '0;
              hi_q      <= '0;
              lo_q      <= bus.op1_i;
              arg_q     <= bus.op2_i;
`ifdef MULDIV_DIV_EN
              funct_q   <= md_funct_e'(bus.funct_i);
`endif
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end
          end
        end
        ST_CALC: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          arg_q <= arg_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q   <= ST_DONE;
            alu_req_q <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= res_nxt;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
  assign bus.result_o   = result_q;
  assign bus.alu_req_o  = alu_req_q;
  assign bus.alu_ctrl_o = alu_req_q ? step_ctrl : ALU_ADD;
  assign bus.alu_op1_o  = alu_req_q ? step_op1 : '0;
  assign bus.alu_op2_o  = alu_req_q ? step_op2 : '0;

endmodule
